// File: rtl/rv_pkg.sv
// Shared definitions for the memory stage: memory-op encodings, FSM state
// encodings, fault codes and small decode helpers.
package rv_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_COMPLETE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_TIMEOUT  = 2'b10
  } fault_e;

  // Encodings above 8 are reserved and behave as "no memory op".
  function automatic mem_op_e decode_op(input logic [3:0] raw);
    decode_op = (raw <= 4'd8) ? mem_op_e'(raw) : MEM_NONE;
  endfunction

  function automatic logic is_store(input mem_op_e op);
    is_store = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] a);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: is_misaligned = a[0];
      MEM_LW, MEM_SW:          is_misaligned = (a != 2'b00);
      default:                 is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memory_phase_if.sv
// Data-memory bus between the memory stage (master) and the data memory
// (slave).
//   dmem_req_o    request, held until ack
//   dmem_we_o     write strobe
//   dmem_be_o     byte enables
//   dmem_addr_o   word-aligned address
//   dmem_wdata_o  lane-replicated store data
//   dmem_rdata_i  read data, valid with ack
//   dmem_ack_i    completes the request
interface memory_phase_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
    input  dmem_rdata_i, dmem_ack_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
    output dmem_rdata_i, dmem_ack_i
  );
endinterface

// File: rtl/load_store_align.sv
// Combinational lane handling for loads and stores.
//   op            memory operation
//   addr          byte address
//   store_data    raw store value (rs2)
//   rdata         raw word from memory
//   be            byte enables for the access
//   addr_aligned  address with the low two bits cleared
//   wdata         store data replicated across lanes
//   load_data     selected lane, sign- or zero-extended
module load_store_align
  import rv_pkg::*;
(
  input  mem_op_e     op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] addr_aligned,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign addr_aligned = {addr[31:2], 2'b00};
  assign lane_b       = rdata[{addr[1:0], 3'b000} +: 8];
  assign lane_h       = rdata[{addr[1], 4'b0000} +: 16];

  always_comb begin
    be        = '0;
    wdata     = '0;
    load_data = '0;

    case (op)
      MEM_LB, MEM_LBU, MEM_SB: be = 4'b0001 << addr[1:0];
      MEM_LH, MEM_LHU, MEM_SH: be = 4'b0011 << {addr[1], 1'b0};
      MEM_LW, MEM_SW:          be = 4'b1111;
      default:                 be = '0;
    endcase

    case (op)
      MEM_SB:  wdata = {4{store_data[7:0]}};
      MEM_SH:  wdata = {2{store_data[15:0]}};
      MEM_SW:  wdata = store_data;
      default: wdata = '0;
    endcase

    case (op)
      MEM_LB:  load_data = {{24{lane_b[7]}}, lane_b};
      MEM_LBU: load_data = {24'd0, lane_b};
      MEM_LH:  load_data = {{16{lane_h[15]}}, lane_h};
      MEM_LHU: load_data = {16'd0, lane_h};
      MEM_LW:  load_data = rdata;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/memory_phase.sv
// Pipeline memory stage: passes ALU results through, performs loads/stores
// over the data-memory bus, and flags misaligned accesses and bus timeouts.
//   clk, reset_n       clock, synchronous active-low reset
//   valid_i .. reg_write_i  instruction from EX
//   dmem               data-memory bus (master side)
//   stall_o            freezes IF/ID/EX while a bus access is outstanding
//   ex_mem_o           ALU result of the instruction held in this stage
//   mem_wb_o, rd_o, reg_write_o, valid_o  writeback
//   fault_o            one-cycle pulse: 01 misaligned, 10 bus timeout
module memory_phase
  import rv_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 valid_i,
  input  logic [31:0]          alu_res_i,
  input  logic [31:0]          store_data_i,
  input  logic [3:0]           mem_op_i,
  input  logic [4:0]           rd_i,
  input  logic                 reg_write_i,
  memory_phase_if.master       dmem,
  output logic                 stall_o,
  output logic [31:0]          ex_mem_o,
  output logic [31:0]          mem_wb_o,
  output logic [4:0]           rd_o,
  output logic                 reg_write_o,
  output logic                 valid_o,
  output logic [1:0]           fault_o
);

  // Counter only needs to reach ACK_TIMEOUT-1.
  localparam int unsigned CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  state_e        state_q, state_d;
  mem_op_e       op_q, op_d, op_in;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [4:0]    hold_rd_q, hold_rd_d;
  logic          hold_rw_q, hold_rw_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   ex_mem_q, ex_mem_d;

  logic          valid_q, valid_d;
  logic [31:0]   wb_q, wb_d;
  logic [4:0]    rd_out_q, rd_out_d;
  logic          rw_out_q, rw_out_d;
  fault_e        fault_q, fault_d;

  logic          req;
  logic [3:0]    be_w;
  logic [31:0]   addr_w, wdata_w, load_w;

  load_store_align u_align (
    .op           (op_q),
    .addr         (addr_q),
    .store_data   (data_q),
    .rdata        (dmem.dmem_rdata_i),
    .be           (be_w),
    .addr_aligned (addr_w),
    .wdata        (wdata_w),
    .load_data    (load_w)
  );

  assign op_in = decode_op(mem_op_i);
  assign req   = (state_q == ST_WAIT_ACK);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      op_q      <= MEM_NONE;
      addr_q    <= '0;
      data_q    <= '0;
      hold_rd_q <= '0;
      hold_rw_q <= 1'b0;
      cnt_q     <= '0;
      ex_mem_q  <= '0;
      valid_q   <= 1'b0;
      wb_q      <= '0;
      rd_out_q  <= '0;
      rw_out_q  <= 1'b0;
      fault_q   <= FAULT_NONE;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      hold_rd_q <= hold_rd_d;
      hold_rw_q <= hold_rw_d;
      cnt_q     <= cnt_d;
      ex_mem_q  <= ex_mem_d;
      valid_q   <= valid_d;
      wb_q      <= wb_d;
      rd_out_q  <= rd_out_d;
      rw_out_q  <= rw_out_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    hold_rd_d = hold_rd_q;
    hold_rw_d = hold_rw_q;
    cnt_d     = cnt_q;
    ex_mem_d  = ex_mem_q;
    valid_d   = 1'b0;
    wb_d      = wb_q;
    rd_out_d  = rd_out_q;
    rw_out_d  = 1'b0;
    fault_d   = FAULT_NONE;

    case (state_q)
      ST_WAIT_ACK: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (dmem.dmem_ack_i) begin
          state_d  = ST_COMPLETE;
          valid_d  = 1'b1;
          wb_d     = load_w;
          rd_out_d = hold_rd_q;
          rw_out_d = hold_rw_q & ~is_store(op_q);
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_IDLE;
          valid_d  = 1'b1;
          rd_out_d = hold_rd_q;
          fault_d  = FAULT_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        // COMPLETE has stall low, so upstream advances this cycle; it must
        // accept a new instruction just like IDLE or that instruction is lost.
        state_d = ST_IDLE;
        if (valid_i) begin
          ex_mem_d  = alu_res_i;
          hold_rd_d = rd_i;
          hold_rw_d = reg_write_i;
          if (op_in == MEM_NONE) begin
            valid_d  = 1'b1;
            wb_d     = alu_res_i;
            rd_out_d = rd_i;
            rw_out_d = reg_write_i;
          end else if (is_misaligned(op_in, alu_res_i[1:0])) begin
            valid_d  = 1'b1;
            wb_d     = alu_res_i;
            rd_out_d = rd_i;
            fault_d  = FAULT_MISALIGN;
          end else begin
            state_d = ST_WAIT_ACK;
            op_d    = op_in;
            addr_d  = alu_res_i;
            data_d  = store_data_i;
            cnt_d   = '0;
          end
        end
      end
    endcase
  end

  assign dmem.dmem_req_o   = req;
  assign dmem.dmem_we_o    = req & is_store(op_q);
  assign dmem.dmem_be_o    = req ? be_w    : '0;
  assign dmem.dmem_addr_o  = req ? addr_w  : '0;
  assign dmem.dmem_wdata_o = req ? wdata_w : '0;

  assign stall_o     = req;
  assign ex_mem_o    = ex_mem_q;
  assign mem_wb_o    = wb_q;
  assign rd_o        = rd_out_q;
  assign reg_write_o = valid_q & rw_out_q;
  assign valid_o     = valid_q;
  assign fault_o     = fault_q;

endmodule

// File: tb/tb_memory_phase.sv
module tb_memory_phase;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_i;
  logic [31:0] alu_res_i;
  logic [31:0] store_data_i;
  logic [3:0]  mem_op_i;
  logic [4:0]  rd_i;
  logic        reg_write_i;
  logic        stall_o;
  logic [31:0] ex_mem_o;
  logic [31:0] mem_wb_o;
  logic [4:0]  rd_o;
  logic        reg_write_o;
  logic        valid_o;
  logic [1:0]  fault_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  memory_phase_if bus ();

  memory_phase #(.ACK_TIMEOUT(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid_i      (valid_i),
    .alu_res_i    (alu_res_i),
    .store_data_i (store_data_i),
    .mem_op_i     (mem_op_i),
    .rd_i         (rd_i),
    .reg_write_i  (reg_write_i),
    .dmem         (bus),
    .stall_o      (stall_o),
    .ex_mem_o     (ex_mem_o),
    .mem_wb_o     (mem_wb_o),
    .rd_o         (rd_o),
    .reg_write_o  (reg_write_o),
    .valid_o      (valid_o),
    .fault_o      (fault_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input logic rw);
    valid_i      = 1'b1;
    mem_op_i     = op;
    alu_res_i    = a;
    store_data_i = d;
    rd_i         = rd;
    reg_write_i  = rw;
    tick();
    valid_i      = 1'b0;
  endtask

  initial begin
    int unsigned stall_cycles;
    int unsigned req_cycles;

    reset_n          = 1'b0;
    valid_i          = 1'b0;
    alu_res_i        = '0;
    store_data_i     = '0;
    mem_op_i         = '0;
    rd_i             = '0;
    reg_write_i      = 1'b0;
    bus.dmem_ack_i   = 1'b0;
    bus.dmem_rdata_i = '0;

    tick();
    tick();
    check_val("rst_valid", 32'(valid_o), 32'd0);
    check_val("rst_req",   32'(bus.dmem_req_o), 32'd0);
    check_val("rst_stall", 32'(stall_o), 32'd0);
    check_val("rst_fault", 32'(fault_o), 32'd0);
    check_val("rst_wb",    mem_wb_o, 32'd0);
    check_val("rst_exmem", ex_mem_o, 32'd0);
    reset_n = 1'b1;
    tick();

    // ALU pass-through
    issue(4'd0, 32'h0000_0042, 32'd0, 5'd5, 1'b1);
    check_val("add_wb",    mem_wb_o, 32'h42);
    check_val("add_valid", 32'(valid_o), 32'd1);
    check_val("add_rd",    32'(rd_o), 32'd5);
    check_val("add_rw",    32'(reg_write_o), 32'd1);
    check_val("add_exmem", ex_mem_o, 32'h42);
    check_val("add_req",   32'(bus.dmem_req_o), 32'd0);
    tick();
    check_val("add_valid_drop", 32'(valid_o), 32'd0);
    check_val("add_rw_drop",    32'(reg_write_o), 32'd0);
    check_val("add_req2",       32'(bus.dmem_req_o), 32'd0);

    // SB 0x1003, ack in the fourth wait cycle
    issue(4'd6, 32'h0000_1003, 32'h0000_00A5, 5'd0, 1'b0);
    stall_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (stall_o) stall_cycles++;
      check_val("sb_req",   32'(bus.dmem_req_o), 32'd1);
      check_val("sb_we",    32'(bus.dmem_we_o), 32'd1);
      check_val("sb_be",    32'(bus.dmem_be_o), 32'h8);
      check_val("sb_addr",  bus.dmem_addr_o, 32'h0000_1000);
      check_val("sb_wdata", bus.dmem_wdata_o, 32'hA5A5_A5A5);
      if (i == 3) bus.dmem_ack_i = 1'b1;
      tick();
    end
    bus.dmem_ack_i = 1'b0;
    check_val("sb_stall_cnt", stall_cycles, 32'd4);
    check_val("sb_stall_end", 32'(stall_o), 32'd0);
    check_val("sb_req_end",   32'(bus.dmem_req_o), 32'd0);
    check_val("sb_valid",     32'(valid_o), 32'd1);
    check_val("sb_rw",        32'(reg_write_o), 32'd0);
    check_val("sb_exmem",     ex_mem_o, 32'h0000_1003);
    tick();

    // SH 0x6002, immediate ack
    issue(4'd7, 32'h0000_6002, 32'hFFFF_1234, 5'd0, 1'b0);
    check_val("sh_be",    32'(bus.dmem_be_o), 32'hC);
    check_val("sh_wdata", bus.dmem_wdata_o, 32'h1234_1234);
    bus.dmem_ack_i = 1'b1;
    tick();
    bus.dmem_ack_i = 1'b0;
    check_val("sh_valid", 32'(valid_o), 32'd1);
    tick();

    // LB / LBU 0x2001, rdata 0x0000_8000
    issue(4'd1, 32'h0000_2001, 32'd0, 5'd7, 1'b1);
    check_val("lb_be",   32'(bus.dmem_be_o), 32'h2);
    check_val("lb_addr", bus.dmem_addr_o, 32'h0000_2000);
    check_val("lb_we",   32'(bus.dmem_we_o), 32'd0);
    bus.dmem_ack_i   = 1'b1;
    bus.dmem_rdata_i = 32'h0000_8000;
    tick();
    bus.dmem_ack_i = 1'b0;
    check_val("lb_wb",    mem_wb_o, 32'hFFFF_FF80);
    check_val("lb_valid", 32'(valid_o), 32'd1);
    check_val("lb_rw",    32'(reg_write_o), 32'd1);
    check_val("lb_rd",    32'(rd_o), 32'd7);
    tick();
    issue(4'd4, 32'h0000_2001, 32'd0, 5'd7, 1'b1);
    bus.dmem_ack_i = 1'b1;
    tick();
    bus.dmem_ack_i = 1'b0;
    check_val("lbu_wb", mem_wb_o, 32'h0000_0080);
    tick();

    // Misaligned LW 0x3002
    issue(4'd3, 32'h0000_3002, 32'd0, 5'd3, 1'b1);
    check_val("mis_fault", 32'(fault_o), 32'h1);
    check_val("mis_valid", 32'(valid_o), 32'd1);
    check_val("mis_rw",    32'(reg_write_o), 32'd0);
    check_val("mis_req",   32'(bus.dmem_req_o), 32'd0);
    check_val("mis_stall", 32'(stall_o), 32'd0);
    tick();
    check_val("mis_fault_pulse", 32'(fault_o), 32'd0);
    check_val("mis_req2",        32'(bus.dmem_req_o), 32'd0);

    // LW 0x4000 with no ack: times out after 4 request cycles
    issue(4'd3, 32'h0000_4000, 32'd0, 5'd4, 1'b1);
    req_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (!bus.dmem_req_o) break;
      req_cycles++;
      tick();
    end
    check_val("to_req_cycles", req_cycles, 32'd4);
    check_val("to_fault",      32'(fault_o), 32'h2);
    check_val("to_valid",      32'(valid_o), 32'd1);
    check_val("to_rw",         32'(reg_write_o), 32'd0);
    check_val("to_stall",      32'(stall_o), 32'd0);
    tick();
    check_val("to_fault_pulse", 32'(fault_o), 32'd0);
    check_val("to_idle_req",    32'(bus.dmem_req_o), 32'd0);

    // Reset during WAIT_ACK, then a late ack
    issue(4'd3, 32'h0000_5000, 32'd0, 5'd9, 1'b1);
    check_val("rw_req_pre", 32'(bus.dmem_req_o), 32'd1);
    reset_n = 1'b0;
    tick();
    check_val("rw_req_rst",   32'(bus.dmem_req_o), 32'd0);
    check_val("rw_stall_rst", 32'(stall_o), 32'd0);
    reset_n          = 1'b1;
    bus.dmem_ack_i   = 1'b1;
    bus.dmem_rdata_i = 32'hDEAD_BEEF;
    tick();
    bus.dmem_ack_i = 1'b0;
    check_val("rw_req_late",   32'(bus.dmem_req_o), 32'd0);
    check_val("rw_valid_late", 32'(valid_o), 32'd0);
    check_val("rw_stall_late", 32'(stall_o), 32'd0);
    tick();
    check_val("rw_valid_after", 32'(valid_o), 32'd0);
    check_val("rw_wb_after",    mem_wb_o, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/memory_phase.md
MEMORY_PHASE -- requirements
Module: memory_phase

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255: maximum cycles to wait for dmem_ack_i before a bus error.
REQ-002 SHALL have ports as follows. Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- valid_i  in  1  EX result valid this cycle.
- alu_res_i  in  32  EX result; address for load/store.
- store_data_i  in  32  forwarded rs2 value for stores.
- mem_op_i  in  4  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; others are treated as none.
- rd_i  in  5  destination register.
- reg_write_i  in  1  destination write enable.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  write strobe.
- dmem_be_o  out  4  byte enables.
- dmem_addr_o  out  32  word-aligned address.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_rdata_i  in  32  read data, valid with ack.
- dmem_ack_i  in  1  completes the request.
- stall_o  out  1  freeze IF/ID/EX.
- ex_mem_o  out  32  forwarding value to EX mux select 2'b10.
- mem_wb_o  out  32  writeback value; forwarding to EX mux select 2'b01.
- rd_o  out  5  writeback register.
- reg_write_o  out  1  writeback enable.
- valid_o  out  1  writeback valid.
- fault_o  out  2  one-cycle pulse: 01 misaligned, 10 bus timeout.

Function
REQ-003 SHALL implement states IDLE, WAIT_ACK, COMPLETE.
REQ-004 In IDLE, an input with valid_i=1 and a non-memory op SHALL produce, one cycle later: mem_wb_o=alu_res_i, rd_o/reg_write_o copied, valid_o=1.
REQ-005 In IDLE, an aligned load/store with valid_i=1 SHALL:
- register the op, address and data;
- enter WAIT_ACK;
- assert dmem_req_o and stall_o from the next cycle.
REQ-006 dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o and dmem_wdata_o SHALL remain stable while in WAIT_ACK until the cycle dmem_ack_i=1.
REQ-007 On dmem_ack_i=1 the FSM SHALL go to COMPLETE, capture the extracted load data, and drop dmem_req_o.
- COMPLETE drives valid_o=1 and mem_wb_o for one cycle, deasserts stall_o, then returns to IDLE.
- A store returns valid_o=1 with reg_write_o=0.
REQ-008 Byte enables SHALL be: B = 0001 shifted by addr[1:0]; H = 0011 shifted by 2*addr[1]; W = 1111.
- dmem_addr_o = {addr[31:2], 2'b00}.
- Store data is replicated per lane: byte ×4, half ×2.
REQ-009 Load extraction SHALL select the lane given by addr[1:0].
- LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
REQ-010 Misalignment is defined as H with addr[0]=1, or W with addr[1:0]≠0.
- A misaligned op SHALL issue no request.
- It pulses fault_o=01, gives valid_o=1 with reg_write_o=0, and has 1-cycle latency.
REQ-011 A wait counter SHALL start at 0 on entry to WAIT_ACK and increment each cycle without ack.
- On reaching ACK_TIMEOUT it drops the request, pulses fault_o=10, gives valid_o=1 with reg_write_o=0, and returns to IDLE.
- Ack in the same cycle as the timeout SHALL win.
REQ-012 ex_mem_o SHALL equal the registered alu_res of the instruction currently held in the stage.
REQ-013 valid_i SHALL be ignored while stall_o=1; the upstream stage holds its inputs.
REQ-014 valid_o SHALL be 0 in every cycle without a completed instruction, and reg_write_o SHALL be gated by valid_o.

Reset
REQ-015 With reset_n=0 at a clock edge, the block SHALL:
- enter IDLE, clear the counter;
- drive all outputs to 0, including dmem_req_o, stall_o, valid_o and fault_o.
- This applies mid-transaction; a late ack after reset SHALL be ignored.

Structure
REQ-016 The mem_op encodings, FSM state encodings and fault codes SHALL live in shared package rv_pkg.
REQ-017 Lane alignment and sign extension SHALL be a combinational sub-module, load_store_align.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- ADD result 0x0000_0042, no mem op → next cycle mem_wb_o=0x42, valid_o=1, dmem_req_o never set.
- SB addr 0x1003, data 0xA5 → be=1000, addr 0x1000, wdata 0xA5A5A5A5; ack after 3 cycles gives stall_o high for 4 cycles.
- LB addr 0x2001, rdata 0x0000_8000 → mem_wb_o=0xFFFF_FF80; LBU same → 0x0000_0080.
- LW addr 0x3002 → no request, fault_o=01, reg_write_o=0.
- LW with no ack, ACK_TIMEOUT=4 → req high for 4 cycles, fault_o=10, return to IDLE.
- reset_n low during WAIT_ACK, then ack → req low, valid_o stays 0.
